// File: rtl/stream_demux.sv
// Registered 1-to-N valid/ready stream demultiplexer with unicast, broadcast
// and a saturating counter of beats discarded for an out-of-range select.
module stream_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  input  logic [SEL_W-1:0]          s_sel,
  input  logic                      s_bcast,
  output logic [CHANNELS-1:0]       m_valid,
  input  logic [CHANNELS-1:0]       m_ready,
  output logic [CHANNELS*WIDTH-1:0] m_data,
  output logic [7:0]                drop_cnt
);

  logic [CHANNELS-1:0]       m_valid_q, m_valid_d;
  logic [CHANNELS*WIDTH-1:0] m_data_q, m_data_d;
  logic [7:0]                drop_q, drop_d;

  logic [CHANNELS-1:0]       free_s;
  logic [CHANNELS-1:0]       sel_hit_s;
  logic [CHANNELS-1:0]       load_s;
  logic                      in_range_s;
  logic                      accept_s;

  // Channel free/select decode; s_ready never looks at s_valid.
  always_comb begin
    free_s    = '0;
    sel_hit_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      free_s[k]    = !m_valid_q[k] || m_ready[k];
      sel_hit_s[k] = !s_bcast && (s_sel == SEL_W'(k));
    end
    in_range_s = |sel_hit_s;
    if (s_bcast) begin
      s_ready = &free_s;
    end else if (in_range_s) begin
      s_ready = |(sel_hit_s & free_s);
    end else begin
      s_ready = 1'b1;
    end
    accept_s = s_valid && s_ready;
  end

  // Next-state for channel registers and the drop counter.
  always_comb begin
    load_s    = '0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    for (int k = 0; k < CHANNELS; k++) begin
      load_s[k] = accept_s && (s_bcast || sel_hit_s[k]);
      if (load_s[k]) begin
        m_valid_d[k]               = 1'b1;
        m_data_d[k*WIDTH +: WIDTH] = s_data;
      end else if (m_ready[k]) begin
        m_valid_d[k] = 1'b0;
      end else begin
        m_valid_d[k] = m_valid_q[k];
      end
    end
    if (accept_s && !s_bcast && !in_range_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= '0;
      m_data_q  <= '0;
      drop_q    <= 8'd0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      drop_q    <= drop_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux: a 4-channel instance for
// routing/backpressure/broadcast and a 3-channel instance for out-of-range drops.
module tb_stream_demux;

  logic        clk;
  logic        rst_n;

  logic        s_valid, s_ready, s_bcast;
  logic [7:0]  s_data;
  logic [1:0]  s_sel;
  logic [3:0]  m_valid, m_ready;
  logic [31:0] m_data;
  logic [7:0]  drop_cnt;

  logic        d3_valid, d3_ready, d3_bcast;
  logic [7:0]  d3_data;
  logic [1:0]  d3_sel;
  logic [2:0]  d3_m_valid, d3_m_ready;
  logic [23:0] d3_m_data;
  logic [7:0]  d3_drop;

  int n_checks = 0;
  int n_fail   = 0;

  stream_demux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel),
    .s_bcast(s_bcast), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .drop_cnt(drop_cnt)
  );

  stream_demux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(d3_valid), .s_ready(d3_ready), .s_data(d3_data), .s_sel(d3_sel),
    .s_bcast(d3_bcast), .m_valid(d3_m_valid), .m_ready(d3_m_ready), .m_data(d3_m_data),
    .drop_cnt(d3_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ch(input int k);
    return m_data[k*8 +: 8];
  endfunction

  // Advance past the next rising edge so inputs change and outputs are sampled away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic b);
    s_valid = v; s_sel = sel; s_data = d; s_bcast = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_sel = 2'd0; s_data = 8'h00; s_bcast = 1'b0; m_ready = 4'hF;
    d3_valid = 1'b0; d3_sel = 2'd0; d3_data = 8'h00; d3_bcast = 1'b0; d3_m_ready = 3'b111;
    repeat (3) step();
    chk("rst_mvalid", m_valid, 32'h0);
    chk("rst_mdata", m_data, 32'h0);
    chk("rst_drop", drop_cnt, 32'h0);
    rst_n = 1'b1;

    // Unicast streaming with all consumers ready
    drive(1'b1, 2'd0, 8'h11, 1'b0);
    chk("uni_rdy0", s_ready, 32'h1);
    step();
    chk("uni_v0", m_valid, 32'b0001);
    chk("uni_d0", ch(0), 32'h11);
    drive(1'b1, 2'd1, 8'h22, 1'b0);
    chk("uni_rdy1", s_ready, 32'h1);
    step();
    chk("uni_v1", m_valid, 32'b0010);
    chk("uni_d1", ch(1), 32'h22);
    drive(1'b1, 2'd2, 8'h33, 1'b0);
    chk("uni_rdy2", s_ready, 32'h1);
    step();
    chk("uni_v2", m_valid, 32'b0100);
    chk("uni_d2", ch(2), 32'h33);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("uni_drained", m_valid, 32'h0);
    chk("uni_hold_d0", ch(0), 32'h11);

    // Backpressure isolation on channel 1
    m_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'hA0, 1'b0);
    chk("bp_rdyA0", s_ready, 32'h1);
    step();
    chk("bp_vA0", m_valid, 32'b0010);
    chk("bp_dA0", ch(1), 32'hA0);
    drive(1'b1, 2'd1, 8'hA1, 1'b0);
    chk("bp_rdyA1_stall", s_ready, 32'h0);
    step();
    chk("bp_holdA0", ch(1), 32'hA0);
    chk("bp_vhold", m_valid, 32'b0010);
    drive(1'b1, 2'd3, 8'hB0, 1'b0);
    chk("bp_rdyB0", s_ready, 32'h1);
    step();
    chk("bp_vB0", m_valid, 32'b1010);
    chk("bp_dB0", ch(3), 32'hB0);
    chk("bp_stillA0", ch(1), 32'hA0);
    drive(1'b1, 2'd1, 8'hA1, 1'b0);
    chk("bp_rdyA1_again", s_ready, 32'h0);
    m_ready = 4'hF;
    #1;
    chk("bp_rdyA1_open", s_ready, 32'h1);
    step();
    chk("bp_vA1", m_valid, 32'b0010);
    chk("bp_dA1", ch(1), 32'hA1);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("bp_nodup", m_valid, 32'h0);

    // Broadcast blocked by a stalled, preloaded channel 1
    m_ready = 4'b1101;
    drive(1'b1, 2'd1, 8'h44, 1'b0);
    step();
    chk("bc_pre", m_valid, 32'b0010);
    drive(1'b1, 2'd0, 8'h5C, 1'b1);
    chk("bc_rdy_blk", s_ready, 32'h0);
    step();
    chk("bc_nopartial", m_valid, 32'b0010);
    chk("bc_rdy_blk2", s_ready, 32'h0);
    m_ready = 4'hF;
    #1;
    chk("bc_rdy_open", s_ready, 32'h1);
    step();
    chk("bc_vall", m_valid, 32'hF);
    chk("bc_dall", m_data, 32'h5C5C5C5C);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("bc_drained", m_valid, 32'h0);

    // Same-cycle drain and refill on channel 0
    drive(1'b1, 2'd0, 8'h01, 1'b0);
    step();
    chk("rf_v01", m_valid, 32'b0001);
    chk("rf_d01", ch(0), 32'h01);
    drive(1'b1, 2'd0, 8'h02, 1'b0);
    chk("rf_rdy", s_ready, 32'h1);
    step();
    chk("rf_v02", m_valid, 32'b0001);
    chk("rf_d02", ch(0), 32'h02);
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    step();
    chk("rf_drained", m_valid, 32'h0);

    // Out-of-range drops on the 3-channel instance
    d3_valid = 1'b1; d3_sel = 2'd3; d3_data = 8'hEE;
    for (int i = 0; i < 260; i++) begin
      #1;
      chk("drop_rdy", d3_ready, 32'h1);
      step();
      chk("drop_mvalid", d3_m_valid, 32'h0);
      if (i == 4) chk("drop_cnt5", d3_drop, 32'd5);
    end
    d3_valid = 1'b0;
    chk("drop_sat", d3_drop, 32'd255);
    chk("drop_mdata", d3_m_data, 32'h0);

    // Asynchronous reset mid-stream with m_valid=1010
    m_ready = 4'h0;
    drive(1'b1, 2'd1, 8'h77, 1'b0);
    step();
    drive(1'b1, 2'd3, 8'h88, 1'b0);
    step();
    drive(1'b0, 2'd0, 8'h00, 1'b0);
    chk("ar_pre_v", m_valid, 32'b1010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_mvalid", m_valid, 32'h0);
    chk("ar_mdata", m_data, 32'h0);
    chk("ar_drop3", d3_drop, 32'h0);
    chk("ar_drop4", drop_cnt, 32'h0);
    step();
    rst_n = 1'b1;
    m_ready = 4'hF;
    drive(1'b1, 2'd2, 8'h9D, 1'b0);
    step();
    chk("post_rst_v", m_valid, 32'b0100);
    chk("post_rst_d", ch(2), 32'h9D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes on every port. It routes each input beat to the output channel chosen by `s_sel`, or copies it to all channels when `s_bcast` is set. Each channel has a one-entry output register, so every channel can sustain full throughput and a stalled channel never corrupts data. The block sits between a single producer and several independent consumers in the datapath.

## Interface
- `WIDTH`, 8: data width in bits.
- `CHANNELS`, 4: number of output channels, 2..16; need not be a power of two.
- `SEL_W`, $clog2(CHANNELS): select width, derived and not overridden.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `s_valid`  in  1: input beat valid.
- `s_ready`  out  1: input beat accepted when `s_valid && s_ready` at the rising edge.
- `s_data`  in  WIDTH: input payload.
- `s_sel`  in  SEL_W: destination channel index.
- `s_bcast`  in  1: broadcast; `s_sel` is ignored when set.
- `m_valid`  out  CHANNELS: per-channel output valid.
- `m_ready`  in  CHANNELS: per-channel consumer ready.
- `m_data`  out  CHANNELS*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `drop_cnt`  out  8: count of beats dropped for an out-of-range `s_sel`; saturates at 255.

## Operation
- Each channel k holds one output register, `m_valid[k]` plus its `m_data` slice.
- A channel is free when `!m_valid[k] || m_ready[k]`, so a drain and a refill can happen in the same cycle.
- Unicast (`s_bcast=0`, `s_sel < CHANNELS`):
  - `s_ready` equals the free state of channel `s_sel`.
  - On a handshake, channel `s_sel` loads `s_data` and `m_valid[s_sel]` becomes 1.
- Broadcast (`s_bcast=1`):
  - `s_ready` is high only when all channels are free.
  - On a handshake, every channel loads `s_data` and all `m_valid` bits become 1. Partial broadcasts never occur.
- Out of range (`s_bcast=0`, `s_sel >= CHANNELS`):
  - `s_ready=1` and the beat is discarded.
  - `drop_cnt` increments by 1 per handshake and holds at 255.
  - No channel state changes.
- Output side:
  - When `m_valid[k] && m_ready[k]` and no new load targets k, `m_valid[k]` clears.
  - `m_data` slice k holds its value while `m_valid[k]=1 && m_ready[k]=0`.
  - `m_data` slice k holds its value after a drain; it is not zeroed.
- `s_ready` is combinational from `s_valid`-independent terms only: `s_sel`, `s_bcast`, `m_valid` and `m_ready`. It never depends on `s_valid`.
- Channels are independent. A stall on channel j never blocks unicast traffic to any other channel.

## Timing
- Reset values: `m_valid=0`, `m_data=0`, `drop_cnt=0`.
- Reset assertion clears all state immediately, without a clock, including mid-transfer. Beats in flight are lost.
- First handshake is possible on the first rising edge after `rst_n` deasserts.
- Latency: a beat accepted at edge n appears on `m_valid`/`m_data` after edge n and can be consumed at edge n+1.
- Throughput: 1 beat/cycle sustained to any channel whose `m_ready` stays high. Broadcast also reaches 1 beat/cycle when all `m_ready` are high.
- Simultaneous drain and load on the same channel:
  - The new data replaces the old.
  - `m_valid` stays 1.
  - No bubble.
- Broadcast with one channel stalled: `s_ready=0` until that channel drains. Other channels drain normally meanwhile.

## Test plan
- Reset: drive `rst_n=0` mid-stream with `m_valid=4'b1010` -> `m_valid=0`, `m_data=0` and `drop_cnt=0` immediately, before any clock edge.
- Unicast streaming: `CHANNELS=4`, `m_ready=4'hF`, send beats 0x11, 0x22, 0x33 with `s_sel`=0,1,2 on consecutive cycles -> each appears one cycle later on channels 0,1,2 in turn, and `s_ready` stays 1 throughout.
- Backpressure isolation: `m_ready[1]=0`, send 0xA0 then 0xA1 to channel 1 and 0xB0 to channel 3:
  - 0xA0 is held on channel 1.
  - `s_ready=0` while 0xA1 is presented.
  - 0xB0 is accepted once presented and delivered on channel 3.
  - Raising `m_ready[1]` delivers 0xA1 with no loss and no duplication.
- Broadcast: send 0x5C with `s_bcast=1` and `m_ready=4'b1101`, after channel 1 was preloaded:
  - `s_ready=0` until channel 1 drains.
  - Then all four channels show 0x5C simultaneously, on the cycle after the handshake.
- Out-of-range drop: `CHANNELS=3`, send 260 beats with `s_sel=3` -> `s_ready=1` on every beat, `m_valid` stays 0, and `drop_cnt` reads 255 at the end.
- Same-cycle refill: channel 0 is valid with 0x01 and `m_ready[0]=1`; present 0x02 to channel 0 -> 0x01 is consumed and 0x02 is loaded on the same edge, with `m_valid[0]` continuously 1.
